// File: rtl/layer_pkg.sv
// layer_pkg: shared defaults, loader state encoding and activation type for the layer loader.
package layer_pkg;
  localparam int DW_DEF = 8;
  localparam int N_IN_DEF = 30;
  localparam int NODE_LAT_DEF = 3;
  typedef enum logic {FILL, WAIT} state_t;
  typedef logic signed [DW_DEF-1:0] act_t;
endpackage

// File: rtl/layer_act_loader_lat_timer.sv
// lat_timer: loadable down-counter that fires a one-cycle done pulse LAT edges after load.
module lat_timer #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expire,
  output logic done
);
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
  logic [CW-1:0] cnt;
  logic active;
  assign expire = active && cnt == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      active <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= expire;
      if (load) begin
        cnt <= CW'(LAT - 1);
        active <= 1'b1;
      end else if (expire) active <= 1'b0;
      else if (active) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/layer_act_loader.sv
// layer_act_loader: assembles a byte-serial activation stream into one atomic parallel vector and times node latency.
// Optional LAYER_ACT_LOADER_OVERLAP_EN: keep filling the next vector during WAIT, holding back only the final slot.
module layer_act_loader
  import layer_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int DW = DW_DEF,
  parameter int NODE_LAT = NODE_LAT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DW-1:0]      s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [N_IN*DW-1:0] act_bus,
  output logic               act_valid,
  output logic               res_valid,
  output logic               busy,
  output logic               err
);
  localparam int IW = $clog2(N_IN);
  localparam logic [IW-1:0] LAST = IW'(N_IN - 1);
  state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [DW-1:0] shadow [N_IN-1];
  logic xfer, at_last, commit, frame_err, ready_nx, expire;
  always_comb begin
    xfer = s_valid & s_ready;
    at_last = idx == LAST;
    commit = xfer & at_last & s_last;
    frame_err = xfer & (s_last ^ at_last);
    idx_nx = !xfer ? idx : (at_last | s_last) ? '0 : idx + IW'(1);
    state_nx = commit ? WAIT : (state == WAIT && expire) ? FILL : state;
`ifdef LAYER_ACT_LOADER_OVERLAP_EN
    ready_nx = state_nx == FILL || idx_nx != LAST;
`else
    ready_nx = state_nx == FILL;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      s_ready <= 1'b1;
      act_valid <= 1'b0;
      err <= 1'b0;
      act_bus <= '0;
      for (int k = 0; k < N_IN - 1; k++) shadow[k] <= '0;
    end else begin
      idx <= idx_nx;
      s_ready <= ready_nx;
      act_valid <= commit;
      err <= err | frame_err;
      if (xfer && !at_last) shadow[idx] <= s_data;
      // whole vector lands on one edge so nodes never see a mix of old and new slots
      if (commit) begin
        for (int k = 0; k < N_IN - 1; k++) act_bus[k*DW +: DW] <= shadow[k];
        act_bus[(N_IN-1)*DW +: DW] <= s_data;
      end
    end
  end
  assign busy = state == WAIT;
  lat_timer #(.LAT(NODE_LAT)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(commit),
    .expire(expire),
    .done(res_valid)
  );
endmodule

// File: doc/layer_act_loader.md
Name: layer_act_loader

Overview:
- Writer side of a layer's activation interface.
- Accepts a byte-serial activation stream with a valid/ready handshake and assembles one full input vector (A0..A(N_IN-1)).
- Presents the vector as one flat parallel bus that feeds every node of a layer at once.
- Times the node pipeline latency and pulses res_valid when the node outputs (Nkx) correspond to that vector.

Parameters:
- N_IN, 30, number of activations per vector (node fan-in).
- DW, 8, activation width in bits.
- NODE_LAT, 3, clock edges from a bus update to a valid node output (input register, sum register, output register).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_data  in  DW  serial activation byte; slot 0 first.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final byte of a vector; qualified by s_valid.
- s_ready  out  1  loader can accept a byte.
- act_bus  out  N_IN*DW  parallel vector; slot k at bits [k*DW+DW-1 : k*DW], driving node input Akx.
- act_valid  out  1  one-cycle strobe: act_bus updated this cycle.
- res_valid  out  1  one-cycle strobe: layer node outputs now reflect the current act_bus.
- busy  out  1  high while in WAIT.
- err  out  1  sticky framing error.

Behaviour:
- Reset (synchronous, active-high) values:
  - act_bus = 0, act_valid = 0, res_valid = 0, busy = 0, err = 0.
  - s_ready = 1 (from the first cycle after reset), slot index idx = 0, shadow buffer = 0, state = FILL.
  - Reset asserted mid-operation discards the partial vector and any pending latency count.
- Handshake:
  - A byte transfers on an edge with s_valid & s_ready.
  - s_ready is a registered output and does not depend combinationally on s_valid.
- State FILL:
  - s_ready = 1.
  - Each transfer writes s_data into shadow[idx] and increments idx.
  - Transfer with idx == N_IN-1 and s_last = 1:
    - at that same edge, act_bus <= {shadow[N_IN-2:0], s_data} as one atomic update (nodes never see a partial vector);
    - act_valid is high the following cycle;
    - idx <= 0; go to WAIT; s_ready drops to 0.
- Framing errors:
  - s_last = 1 with idx < N_IN-1, or s_last = 0 with idx == N_IN-1, sets err.
  - The vector is discarded, idx <= 0, act_bus unchanged, no act_valid.
  - Remain in FILL.
- State WAIT:
  - busy = 1; a down-counter is loaded with NODE_LAT-1 on entry.
  - res_valid rises at the NODE_LAT-th edge after the act_bus update edge (act_valid at T+1 cycle, res_valid at T+NODE_LAT cycle), high for exactly one cycle.
  - At that edge, return to FILL with s_ready = 1.
- act_bus holds stable from its update edge until the next committed vector. It is never cleared except by reset.
- s_data and s_valid are ignored while s_ready = 0. Upstream must hold data (standard valid/ready).
- NODE_LAT = 1: WAIT lasts one cycle. NODE_LAT must be ≥ 1.

Optional Feature:
- Macro: LAYER_ACT_LOADER_OVERLAP_EN.
- Defined:
  - s_ready stays 1 during WAIT, and bytes fill the shadow buffer for the next vector.
  - Slot N_IN-1 is not accepted until WAIT ends: s_ready = 0 while idx == N_IN-1 and state == WAIT.
  - On the res_valid cycle the last byte may transfer, committing the next vector on that edge (back-to-back WAIT).
  - Framing checks are unchanged.
- Undefined: s_ready = 0 for all of WAIT, as described above.

Decomposition:
- Package layer_pkg:
  - DW, N_IN, NODE_LAT defaults;
  - the state enum {FILL, WAIT};
  - the act_t typedef (logic signed [DW-1:0]).
- One natural sub-module, lat_timer: a loadable down-counter producing the single-cycle done pulse (res_valid). Slot storage stays inline.

Test Plan:
- Stream bytes 1..30 with s_valid held high and s_last on byte 30 → act_bus slot0 = 8'd1, slot29 = 8'd30; act_valid for 1 cycle; res_valid exactly NODE_LAT=3 edges after the update edge; s_ready = 0 for 3 cycles.
- Assert s_last on byte 12 → err = 1, act_bus stays at its previous value, no act_valid; the next clean 30-byte vector commits normally with err still 1.
- Random s_valid gaps (≈50%) over a 30-byte vector of 8'h80..8'h9D → bus is correct (slot k = 8'h80+k), no byte lost or duplicated.
- Pulse reset after byte 17 → all outputs at reset values next cycle; a fresh 30-byte vector then commits with slot0 = first post-reset byte.
- Connect to one layer node (weights all 8'd1, bias 0), vector all 8'd64 → at res_valid node output = 8'd127 (saturated), and act_bus is stable throughout WAIT.
- With LAYER_ACT_LOADER_OVERLAP_EN, two back-to-back vectors → bytes 0..28 of vector 2 accepted during WAIT, byte 29 accepted on the res_valid cycle, second act_valid on the following cycle.
